wb_gpio: RTL and testbench

Parametrised Wishbone GPIO peripheral that generalises the fixed 4-bit LED slave.
- NOUT output pins with write, set and clear access.
- NIN input pins with 2-flop synchronisers, per-pin debounce, and per-pin rising/falling edge interrupt capture.
- Single level irq output.
- Sits behind the Wishbone crossbar as one slave (e.g. at 0x10000000, size 0x1000), driving the LEDs and sampling switches/buttons.

---
 rtl/wb_gpio_if.sv | 23 ++
 rtl/wb_gpio.sv | 126 ++++++++++++
 tb/tb_wb_gpio.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_if.sv
// rtl/wb_gpio_if.sv - Wishbone B4 pipelined bus bundle used by wb_gpio
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        stall;
  logic        err;

  modport slave (
    input  adr, dat_m, sel, we, cyc, stb,
    output dat_s, ack, stall, err
  );

  modport master (
    output adr, dat_m, sel, we, cyc, stb,
    input  dat_s, ack, stall, err
  );
endinterface

// File: rtl/wb_gpio.sv
// rtl/wb_gpio.sv - Wishbone GPIO: set/clear outputs, synchronised inputs, edge interrupts
// Define GPIO_DEBOUNCE_EN to add per-pin debounce counters (DEBOUNCE_CYCLES).
module wb_gpio #(
  parameter int NOUT            = 4,
  parameter int NIN             = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  wb_if.slave             wb,
  input  logic [NIN-1:0]  gpio_in,
  output logic [NOUT-1:0] gpio_out,
  output logic            irq
);
  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_RISE = 3'd2;
  localparam logic [2:0] OFF_FALL = 3'd3;
  localparam logic [2:0] OFF_PEND = 3'd4;
  localparam logic [2:0] OFF_SET  = 3'd5;
  localparam logic [2:0] OFF_CLR  = 3'd6;

  logic [NOUT-1:0] out_q;
  logic [NIN-1:0]  rise_en, fall_en, pend, pend_clr;
  logic [NIN-1:0]  sync0, sync1, d, d_next, rise, fall;
  logic            req, wr, rd;
  logic [2:0]      off;
  logic [31:0]     wmask, wdata_m, rdata;
  logic            unused_bits;

  assign req         = wb.cyc & wb.stb;
  assign wr          = req & wb.we;
  assign rd          = req & ~wb.we;
  assign off         = wb.adr[4:2];
  assign wmask       = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
  assign wdata_m     = wb.dat_m & wmask;
  assign wb.stall    = 1'b0;
  assign wb.err      = 1'b0;
  assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0]};
  assign gpio_out    = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= gpio_in;
      sync1 <= sync0;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [NIN];

  // The pin is accepted on the DEBOUNCE_CYCLES-th consecutive cycle that it differs from d.
  always_comb begin
    d_next = d;
    for (int i = 0; i < NIN; i++) begin
      if (sync1[i] != d[i] && cnt[i] == CNT_MAX) d_next[i] = sync1[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      d <= d_next;
      for (int i = 0; i < NIN; i++) begin
        if (sync1[i] == d[i] || cnt[i] == CNT_MAX) cnt[i] <= '0;
        else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`else
  assign d      = sync1;
  assign d_next = sync0;
`endif

  assign rise     = d_next & ~d;
  assign fall     = ~d_next & d;
  assign pend_clr = (wr && off == OFF_PEND) ? wdata_m[NIN-1:0] : '0;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT:  rdata[NOUT-1:0] = out_q;
      OFF_IN:   rdata[NIN-1:0]  = d;
      OFF_RISE: rdata[NIN-1:0]  = rise_en;
      OFF_FALL: rdata[NIN-1:0]  = fall_en;
      OFF_PEND: rdata[NIN-1:0]  = pend;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pend     <= '0;
      irq      <= 1'b0;
      wb.ack   <= 1'b0;
      wb.dat_s <= '0;
    end else begin
      wb.ack   <= req;
      wb.dat_s <= rd ? rdata : '0;
      irq      <= |pend;
      // New edges are OR-ed in after the clear so a coincident event survives.
      pend     <= (pend & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
      if (wr) begin
        case (off)
          OFF_OUT:  out_q   <= (out_q & ~wmask[NOUT-1:0]) | wdata_m[NOUT-1:0];
          OFF_RISE: rise_en <= (rise_en & ~wmask[NIN-1:0]) | wdata_m[NIN-1:0];
          OFF_FALL: fall_en <= (fall_en & ~wmask[NIN-1:0]) | wdata_m[NIN-1:0];
          OFF_SET:  out_q   <= out_q | wdata_m[NOUT-1:0];
          OFF_CLR:  out_q   <= out_q & ~wdata_m[NOUT-1:0];
          default:  ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_gpio.sv
// tb/tb_wb_gpio.sv - directed and randomized bench for wb_gpio against a cycle-level reference model
module tb_wb_gpio;
  localparam int NOUT = 4;
  localparam int NIN  = 8;
  localparam int DC   = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NIN-1:0]  gpio_in;
  logic [NOUT-1:0] gpio_out;
  logic            irq;
  wb_if            wb_bus ();

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  wb_gpio #(.NOUT(NOUT), .NIN(NIN), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .wb(wb_bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register state plus a raw-input history; an input is accepted
  // once the last DC synchronised samples all disagree with the accepted value.
  logic [NIN-1:0]  raw [$];
  logic [NOUT-1:0] m_out;
  logic [NIN-1:0]  m_ren, m_fen, m_pend, m_d, nd, set_bits, clr;
  logic            m_irq, m_ack, m_req, stable;
  logic [31:0]     m_dat, mask, wd;
  logic [2:0]      m_off;

  function automatic logic [31:0] m_read(input logic [2:0] o);
    case (o)
      3'd0:    return 32'(m_out);
      3'd1:    return 32'(m_d);
      3'd2:    return 32'(m_ren);
      3'd3:    return 32'(m_fen);
      3'd4:    return 32'(m_pend);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DC + 4; i++) raw.push_back('0);
    m_out = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_d = '0;
    m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
  end

  always @(posedge clk) begin
    m_req = wb_bus.cyc & wb_bus.stb;
    if (rst) begin
      raw.push_back('0);
      m_out = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_d = '0;
      m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
    end else begin
      raw.push_back(gpio_in);
      nd = m_d;
`ifdef GPIO_DEBOUNCE_EN
      for (int p = 0; p < NIN; p++) begin
        stable = 1'b1;
        for (int j = 0; j < DC; j++)
          if (raw[raw.size() - 3 - j][p] == m_d[p]) stable = 1'b0;
        if (stable) nd[p] = ~m_d[p];
      end
`else
      nd = raw[raw.size() - 2];
`endif
      set_bits = (nd & ~m_d & m_ren) | (~nd & m_d & m_fen);
      mask = '0;
      for (int b = 0; b < 4; b++) if (wb_bus.sel[b]) mask[8*b +: 8] = 8'hFF;
      wd = wb_bus.dat_m & mask;
      m_off = wb_bus.adr[4:2];
      m_ack = m_req;
      m_dat = (m_req && !wb_bus.we) ? m_read(m_off) : 32'd0;
      m_irq = |m_pend;
      clr = '0;
      if (m_req && wb_bus.we) begin
        case (m_off)
          3'd0: m_out = NOUT'((32'(m_out) & ~mask) | wd);
          3'd2: m_ren = NIN'((32'(m_ren) & ~mask) | wd);
          3'd3: m_fen = NIN'((32'(m_fen) & ~mask) | wd);
          3'd4: clr   = NIN'(wd);
          3'd5: m_out = NOUT'(32'(m_out) | wd);
          3'd6: m_out = NOUT'(32'(m_out) & ~wd);
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr) | set_bits;
      m_d = nd;
    end
    while (raw.size() > DC + 4) void'(raw.pop_front());
  end

  always @(negedge clk) begin
    if (checking) begin
      check_eq("cyc_ack", 32'(wb_bus.ack), 32'(m_ack));
      check_eq("cyc_dat_s", wb_bus.dat_s, m_dat);
      check_eq("cyc_gpio_out", 32'(gpio_out), 32'(m_out));
      check_eq("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] o, input logic [31:0] data,
                           input logic [3:0] s);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = o;
    a[1:0] = 2'b00;
    wb_bus.adr = a; wb_bus.we = we; wb_bus.dat_m = data; wb_bus.sel = s;
    wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1;
  endtask

  task automatic idle_bus();
    wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [2:0] o, input logic [31:0] data,
                     input logic [3:0] s, output logic [31:0] rdata);
    drive_req(we, o, data, s);
    tick();
    idle_bus();
    check_eq("bus_ack", 32'(wb_bus.ack), 32'd1);
    rdata = wb_bus.dat_s;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] data);
    logic [31:0] r;
    bus(1'b1, o, data, 4'hF, r);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] o, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, o, 32'd0, 4'hF, r);
    check_eq(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; gpio_in = '0;
    wb_bus.adr = '0; wb_bus.dat_m = '0; wb_bus.sel = '0;
    wb_bus.we = 1'b0; wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checking = 1'b1;

    check_eq("rst_gpio_out", 32'(gpio_out), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("stall", 32'(wb_bus.stall), 32'd0);
    check_eq("err", 32'(wb_bus.err), 32'd0);
    for (int o = 0; o < 8; o++) rd_chk("rst_read", 3'(o), 32'd0);

    wr(3'd0, 32'hA);  check_eq("out_write", 32'(gpio_out), 32'hA);
    wr(3'd5, 32'h5);  check_eq("out_set", 32'(gpio_out), 32'hF);
    wr(3'd6, 32'h3);  check_eq("out_clr", 32'(gpio_out), 32'hC);
    rd_chk("out_read", 3'd0, 32'hC);
    bus(1'b1, 3'd0, 32'hFFFF_FFFF, 4'b0001, r);
    rd_chk("out_width", 3'd0, 32'hF);
    rd_chk("set_reads0", 3'd5, 32'd0);
    bus(1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0010, r);
    rd_chk("rise_en_lane", 3'd2, 32'd0);
    wr(3'd2, 32'hFFFF_FFFF);
    rd_chk("rise_en_width", 3'd2, 32'hFF);
    wr(3'd2, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 8'h01;
    repeat (10) tick();
    gpio_in = 8'h00;
    repeat (LAT + 2) tick();
    rd_chk("glitch_in", 3'd1, 32'd0);
`endif
    gpio_in = 8'h01;
    repeat (LAT - 1) tick();
    rd_chk("in_before_lat", 3'd1, 32'd0);
    rd_chk("in_after_lat", 3'd1, 32'd1);

    gpio_in = 8'h02;
    repeat (LAT + 2) tick();
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h2);
    gpio_in = 8'h01;
    repeat (LAT + 2) tick();
    rd_chk("pend_both", 3'd4, 32'h3);
    check_eq("irq_set", 32'(irq), 32'd1);
    wr(3'd4, 32'h1);
    rd_chk("pend_w1c0", 3'd4, 32'h2);
    check_eq("irq_still", 32'(irq), 32'd1);
    wr(3'd4, 32'h2);
    check_eq("irq_lag", 32'(irq), 32'd1);
    tick();
    check_eq("irq_clear", 32'(irq), 32'd0);

    gpio_in = 8'h00;
    repeat (LAT + 2) tick();
    rd_chk("pend_no_fall_en", 3'd4, 32'd0);
    gpio_in = 8'h01;
    repeat (LAT - 1) tick();
    wr(3'd4, 32'h1);
    rd_chk("pend_set_wins", 3'd4, 32'h1);
    wr(3'd4, 32'h1);
    rd_chk("pend_cleared", 3'd4, 32'h0);

    rst = 1'b1;
    drive_req(1'b1, 3'd0, 32'h5, 4'hF);
    tick();
    rst = 1'b0;
    idle_bus();
    check_eq("rst_req_ack", 32'(wb_bus.ack), 32'd0);
    check_eq("rst_req_out", 32'(gpio_out), 32'd0);
    drive_req(1'b1, 3'd0, 32'h6, 4'hF);
    tick();
    check_eq("b2b_ack0", 32'(wb_bus.ack), 32'd1);
    check_eq("b2b_out", 32'(gpio_out), 32'h6);
    drive_req(1'b0, 3'd0, 32'd0, 4'hF);
    tick();
    check_eq("b2b_ack1", 32'(wb_bus.ack), 32'd1);
    check_eq("b2b_rd_out", wb_bus.dat_s, 32'h6);
    drive_req(1'b0, 3'd2, 32'd0, 4'hF);
    tick();
    idle_bus();
    check_eq("b2b_ack2", 32'(wb_bus.ack), 32'd1);
    check_eq("b2b_rd_rise", wb_bus.dat_s, 32'h0);
    drive_req(1'b0, 3'd0, 32'd0, 4'hF);
    tick();
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_kills_ack", 32'(wb_bus.ack), 32'd0);

    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(7) == 0) gpio_in[$urandom_range(NIN - 1)] ^= 1'b1;
      rst = ($urandom_range(199) == 0);
      if ($urandom_range(1) == 1)
        drive_req(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom(), 4'($urandom_range(15)));
      else
        idle_bus();
      tick();
    end
    idle_bus();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
